// File: rtl/vga_timing_pkg.sv
// Shared 640x480 raster timing constants. Renderers import this instead of
// hard-coding the active-window offsets.
package vga_timing_pkg;

  localparam int CNT_W   = 10;
  localparam int PIX_Y_W = 9;
  localparam int FCNT_W  = 8;

  localparam int DEF_CLK_DIV     = 4;
  localparam int DEF_TICK_FRAMES = 6;

  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_H_DISP = 640;
  localparam int DEF_H_FP   = 16;

  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;
  localparam int DEF_V_DISP = 480;
  localparam int DEF_V_FP   = 10;

  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BP + DEF_H_DISP + DEF_H_FP;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BP + DEF_V_DISP + DEF_V_FP;

  localparam int H_ACT_START = DEF_H_SYNC + DEF_H_BP;
  localparam int H_ACT_END   = H_ACT_START + DEF_H_DISP - 1;
  localparam int V_ACT_START = DEF_V_SYNC + DEF_V_BP;
  localparam int V_ACT_END   = V_ACT_START + DEF_V_DISP - 1;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic logic in_window(input cnt_t val, input cnt_t lo, input cnt_t hi);
    return (val >= lo) && (val <= hi);
  endfunction

endpackage

// File: rtl/vga_sync_gen_pix_en_div.sv
// Pixel-rate strobe: div_cnt wraps every CLK_DIV clocks and pix_en is a
// registered one-clock pulse while div_cnt sits at its terminal value.
module pix_en_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic pix_en
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic          pix_en_q, pix_en_d;

  always_comb begin
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DW'(1);
    // Decoded from the next count so pix_en lines up with div_cnt == CLK_DIV-1.
    pix_en_d  = (div_cnt_d == DIV_LAST);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q <= '0;
      pix_en_q  <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      pix_en_q  <= pix_en_d;
    end
  end

  assign pix_en = pix_en_q;

endmodule

// File: rtl/vga_sync_gen.sv
// Raster counters, sync/blank/coordinate decode and the frame/move strobes
// that pace the game logic.
import vga_timing_pkg::*;

module vga_sync_gen #(
  parameter int CLK_DIV     = DEF_CLK_DIV,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int H_DISP      = DEF_H_DISP,
  parameter int H_FP        = DEF_H_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter int V_DISP      = DEF_V_DISP,
  parameter int V_FP        = DEF_V_FP,
  parameter int TICK_FRAMES = DEF_TICK_FRAMES
) (
  input  logic               Clk,
  input  logic               Reset,
  output logic               pix_en,
  output logic [CNT_W-1:0]   hCount,
  output logic [CNT_W-1:0]   vCount,
  output logic               hSync,
  output logic               vSync,
  output logic               Bright,
  output logic [CNT_W-1:0]   pixel_x,
  output logic [PIX_Y_W-1:0] pixel_y,
  output logic               frame_tick,
  output logic               move_tick
);

  localparam int H_TOT    = H_SYNC + H_BP + H_DISP + H_FP;
  localparam int V_TOT    = V_SYNC + V_BP + V_DISP + V_FP;
  localparam int H_LO     = H_SYNC + H_BP;
  localparam int H_HI     = H_LO + H_DISP - 1;
  localparam int V_LO     = V_SYNC + V_BP;
  localparam int V_HI     = V_LO + V_DISP - 1;
  localparam int V_FP_ROW = V_LO + V_DISP;

  logic pix_en_w;

  pix_en_div #(.CLK_DIV(CLK_DIV)) u_pix_en_div (
    .clk    (Clk),
    .reset  (Reset),
    .pix_en (pix_en_w)
  );

  cnt_t                hcount_q, hcount_d;
  cnt_t                vcount_q, vcount_d;
  logic                hsync_q, hsync_d;
  logic                vsync_q, vsync_d;
  logic                bright_q, bright_d;
  cnt_t                pixel_x_q, pixel_x_d;
  logic [PIX_Y_W-1:0]  pixel_y_q, pixel_y_d;
  logic                frame_tick_q, frame_tick_d;
  logic                move_tick_q, move_tick_d;
  logic [FCNT_W-1:0]   fcnt_q, fcnt_d;
  cnt_t                y_off;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (pix_en_w) begin
      if (hcount_q == CNT_W'(H_TOT - 1)) begin
        hcount_d = '0;
        vcount_d = (vcount_q == CNT_W'(V_TOT - 1)) ? '0 : vcount_q + CNT_W'(1);
      end else begin
        hcount_d = hcount_q + CNT_W'(1);
      end
    end
  end

  // Flags and coordinates come from the next counter values so they are
  // registered alongside the counters with no skew.
  always_comb begin
    hsync_d   = (hcount_d >= CNT_W'(H_SYNC));
    vsync_d   = (vcount_d >= CNT_W'(V_SYNC));
    bright_d  = in_window(hcount_d, CNT_W'(H_LO), CNT_W'(H_HI)) &&
                in_window(vcount_d, CNT_W'(V_LO), CNT_W'(V_HI));
    y_off     = vcount_d - CNT_W'(V_LO);
    pixel_x_d = bright_d ? (hcount_d - CNT_W'(H_LO)) : '0;
    pixel_y_d = bright_d ? y_off[PIX_Y_W-1:0] : '0;
  end

  // Gated by pix_en so the tick fires once on the loading edge, not for the
  // whole CLK_DIV hold of that pixel.
  always_comb begin
    frame_tick_d = pix_en_w && (hcount_d == '0) && (vcount_d == CNT_W'(V_FP_ROW));
    fcnt_d       = fcnt_q;
    move_tick_d  = 1'b0;
    if (frame_tick_d) begin
      if (fcnt_q == FCNT_W'(TICK_FRAMES - 1)) begin
        fcnt_d      = '0;
        move_tick_d = 1'b1;
      end else begin
        fcnt_d = fcnt_q + FCNT_W'(1);
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      hcount_q     <= '0;
      vcount_q     <= '0;
      hsync_q      <= 1'b0;
      vsync_q      <= 1'b0;
      bright_q     <= 1'b0;
      pixel_x_q    <= '0;
      pixel_y_q    <= '0;
      frame_tick_q <= 1'b0;
      move_tick_q  <= 1'b0;
      fcnt_q       <= '0;
    end else begin
      hcount_q     <= hcount_d;
      vcount_q     <= vcount_d;
      hsync_q      <= hsync_d;
      vsync_q      <= vsync_d;
      bright_q     <= bright_d;
      pixel_x_q    <= pixel_x_d;
      pixel_y_q    <= pixel_y_d;
      frame_tick_q <= frame_tick_d;
      move_tick_q  <= move_tick_d;
      fcnt_q       <= fcnt_d;
    end
  end

  assign pix_en     = pix_en_w;
  assign hCount     = hcount_q;
  assign vCount     = vcount_q;
  assign hSync      = hsync_q;
  assign vSync      = vsync_q;
  assign Bright     = bright_q;
  assign pixel_x    = pixel_x_q;
  assign pixel_y    = pixel_y_q;
  assign frame_tick = frame_tick_q;
  assign move_tick  = move_tick_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, shrunk timing with
// CLK_DIV=3/TICK_FRAMES=3, shrunk timing with CLK_DIV=1/TICK_FRAMES=1) checked
// every cycle against a closed-form raster model.
module tb_vga_sync_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic run = 1'b0;
  int   t_a = 0, t_b = 0, t_c = 0;

  always @(posedge clk) begin
    t_a <= rst_a ? 0 : t_a + 1;
    t_b <= rst_b ? 0 : t_b + 1;
    t_c <= rst_c ? 0 : t_c + 1;
  end

  // ---------------- DUTs ----------------
  logic       pe_a, hs_a, vs_a, br_a, ft_a, mt_a;
  logic [9:0] h_a, v_a, px_a;
  logic [8:0] py_a;
  logic       pe_b, hs_b, vs_b, br_b, ft_b, mt_b;
  logic [9:0] h_b, v_b, px_b;
  logic [8:0] py_b;
  logic       pe_c, hs_c, vs_c, br_c, ft_c, mt_c;
  logic [9:0] h_c, v_c, px_c;
  logic [8:0] py_c;

  vga_sync_gen u_dut_a (
    .Clk(clk), .Reset(rst_a), .pix_en(pe_a), .hCount(h_a), .vCount(v_a),
    .hSync(hs_a), .vSync(vs_a), .Bright(br_a), .pixel_x(px_a), .pixel_y(py_a),
    .frame_tick(ft_a), .move_tick(mt_a)
  );

  vga_sync_gen #(
    .CLK_DIV(3), .H_SYNC(3), .H_BP(2), .H_DISP(6), .H_FP(2),
    .V_SYNC(2), .V_BP(2), .V_DISP(4), .V_FP(2), .TICK_FRAMES(3)
  ) u_dut_b (
    .Clk(clk), .Reset(rst_b), .pix_en(pe_b), .hCount(h_b), .vCount(v_b),
    .hSync(hs_b), .vSync(vs_b), .Bright(br_b), .pixel_x(px_b), .pixel_y(py_b),
    .frame_tick(ft_b), .move_tick(mt_b)
  );

  vga_sync_gen #(
    .CLK_DIV(1), .H_SYNC(2), .H_BP(1), .H_DISP(4), .H_FP(1),
    .V_SYNC(1), .V_BP(1), .V_DISP(3), .V_FP(2), .TICK_FRAMES(1)
  ) u_dut_c (
    .Clk(clk), .Reset(rst_c), .pix_en(pe_c), .hCount(h_c), .vCount(v_c),
    .hSync(hs_c), .vSync(vs_c), .Bright(br_c), .pixel_x(px_c), .pixel_y(py_c),
    .frame_tick(ft_c), .move_tick(mt_c)
  );

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       hsync;
    logic       vsync;
    logic       bright;
    logic [9:0] px;
    logic [8:0] py;
    logic       ft;
    logic       mt;
  } obs_t;

  // Number of pixel advances after t clocks out of reset.
  function automatic int pix_count(input int t, input int d);
    if (t <= 0) return 0;
    if (d == 1) return t - 1;
    return t / d;
  endfunction

  function automatic obs_t ref_out(input int t, input int d,
                                   input int hsl, input int hbp, input int hdi, input int hfp,
                                   input int vsl, input int vbp, input int vdi, input int vfp,
                                   input int tf);
    obs_t r;
    int ht, vt, p, pp, fs, fl, n, h, v;
    bit bh, bv;
    r = '0;
    if (t == 0) return r;
    ht = hsl + hbp + hdi + hfp;
    vt = vsl + vbp + vdi + vfp;
    fl = ht * vt;
    p  = pix_count(t, d);
    pp = pix_count(t - 1, d);
    h  = p % ht;
    v  = (p / ht) % vt;
    r.pix_en = ((t % d) == d - 1);
    r.h      = 10'(h);
    r.v      = 10'(v);
    r.hsync  = (h >= hsl);
    r.vsync  = (v >= vsl);
    bh = (h >= hsl + hbp) && (h < hsl + hbp + hdi);
    bv = (v >= vsl + vbp) && (v < vsl + vbp + vdi);
    r.bright = bh && bv;
    r.px     = r.bright ? 10'(h - hsl - hbp) : 10'd0;
    r.py     = r.bright ? 9'(v - vsl - vbp) : 9'd0;
    fs   = (vsl + vbp + vdi) * ht;
    r.ft = (p != pp) && ((p % fl) == fs);
    n    = (p >= fs) ? (p - fs) / fl + 1 : 0;
    r.mt = r.ft && ((n % tf) == 0);
    return r;
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h (t_a=%0d t_b=%0d t_c=%0d)", tag, got, exp, t_a, t_b, t_c);
    end
  endtask

  obs_t got_a, got_b, got_c;
  assign got_a = '{pe_a, h_a, v_a, hs_a, vs_a, br_a, px_a, py_a, ft_a, mt_a};
  assign got_b = '{pe_b, h_b, v_b, hs_b, vs_b, br_b, px_b, py_b, ft_b, mt_b};
  assign got_c = '{pe_c, h_c, v_c, hs_c, vs_c, br_c, px_c, py_c, ft_c, mt_c};

  int   hsync_low_a = 0;
  bit   b_phase1    = 1'b0;
  int   ft_cnt_b    = 0;
  int   mt_mask_b   = 0;
  logic br_b_prev   = 1'b0;

  always @(negedge clk) begin
    if (run) begin
      check_val("a_cycle", 64'(got_a), 64'(ref_out(t_a, 4, 96, 48, 640, 16, 2, 33, 480, 10, 6)));
      check_val("b_cycle", 64'(got_b), 64'(ref_out(t_b, 3, 3, 2, 6, 2, 2, 2, 4, 2, 3)));
      check_val("c_cycle", 64'(got_c), 64'(ref_out(t_c, 1, 2, 1, 4, 1, 1, 1, 3, 2, 1)));
      if (t_a < 3200 && !hs_a) hsync_low_a++;
      if (b_phase1 && ft_b) begin
        ft_cnt_b++;
        if (mt_b) mt_mask_b |= (1 << ft_cnt_b);
      end
      if (b_phase1 && br_b && !br_b_prev) begin
        check_val("b_bright_rise_h", 64'(h_b), 64'd5);
        check_val("b_bright_rise_px", 64'(px_b), 64'd0);
      end
      if (b_phase1 && !br_b && br_b_prev && t_b > 0)
        check_val("b_bright_fall_h", 64'(h_b), 64'd11);
      br_b_prev = br_b;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_a();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    check_val("a_first_pix_en", 64'(pe_a), 64'd1);
    check_val("a_first_h", 64'(h_a), 64'd0);
    @(negedge clk);
    check_val("a_h_after_pix_en", 64'(h_a), 64'd1);
    check_val("a_pix_en_drop", 64'(pe_a), 64'd0);
    while (t_a < 3200) @(negedge clk);
    check_val("a_line_wrap_h", 64'(h_a), 64'd0);
    check_val("a_line_wrap_v", 64'(v_a), 64'd1);
    check_val("a_hsync_low_clks", 64'(hsync_low_a), 64'd384);
    repeat ($urandom_range(50, 400)) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    check_val("a_midline_reset", 64'(got_a), 64'd0);
    rst_a = 1'b0;
    repeat (200) @(negedge clk);
  endtask

  task automatic drive_b();
    b_phase1 = 1'b1;
    while (t_b < 2700) @(negedge clk);
    b_phase1 = 1'b0;
    check_val("b_frame_ticks", 64'(ft_cnt_b), 64'd7);
    check_val("b_move_mask", 64'(mt_mask_b), 64'h48);
    // next frame_tick would load on the edge after t_b = 312 + 7*390 - 1
    while (t_b < 3041) @(negedge clk);
    rst_b = 1'b1;
    @(negedge clk);
    check_val("b_tick_edge_reset_ft", 64'(ft_b), 64'd0);
    check_val("b_tick_edge_reset_mt", 64'(mt_b), 64'd0);
    check_val("b_tick_edge_reset_v", 64'(v_b), 64'd0);
    rst_b = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 199) == 0) begin
        rst_b = 1'b1;
        repeat ($urandom_range(1, 3)) @(negedge clk);
        rst_b = 1'b0;
      end
    end
  endtask

  task automatic drive_c();
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 99) == 0) begin
        rst_c = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk);
        rst_c = 1'b0;
      end
    end
  endtask

  // ---------------- main ----------------
  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    rst_c = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    rst_c = 1'b0;
    run   = 1'b1;
    check_val("a_reset_state", 64'(got_a), 64'd0);
    check_val("b_reset_state", 64'(got_b), 64'd0);
    fork
      drive_a();
      drive_b();
      drive_c();
    join
    run = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

Raster timing generator for the 640x480 VGA display path: divides the system clock to a pixel enable, runs the horizontal/vertical counters, and drives the sync, blanking and coordinate signals consumed by the pixel renderers (hCount/vCount/Bright in, rgb out). It also emits a per-frame tick and a slower movement tick, which serve as the game-logic advance strobes. It sits between the board clock/reset and every renderer and game-state block.

## Interface
- CLK_DIV, 4: system clocks per pixel (100 MHz -> 25 MHz); legal 1..16
- H_SYNC, 96 / H_BP, 48 / H_DISP, 640 / H_FP, 16: horizontal segment lengths in pixels; H_TOTAL = 800
- V_SYNC, 2 / V_BP, 33 / V_DISP, 480 / V_FP, 10: vertical segment lengths in lines; V_TOTAL = 525
- TICK_FRAMES, 6: frames per move_tick; legal 1..255

- Clk  in  1  system clock; the only clock
- Reset  in  1  synchronous, active-high
- pix_en  out  1  one-Clk pulse every CLK_DIV cycles; counters advance on it
- hCount  out  10  horizontal count 0..H_TOTAL-1
- vCount  out  10  vertical count 0..V_TOTAL-1
- hSync  out  1  active-low, low while hCount < H_SYNC
- vSync  out  1  active-low, low while vCount < V_SYNC
- Bright  out  1  high inside the active area
- pixel_x  out  10  hCount-144 when Bright, else 0
- pixel_y  out  9  vCount-35 when Bright, else 0
- frame_tick  out  1  one-Clk pulse at the start of vertical front porch
- move_tick  out  1  one-Clk pulse on every TICK_FRAMES-th frame_tick

## Operation
- Divider div_cnt counts 0..CLK_DIV-1 and wraps. pix_en is registered and is high exactly when div_cnt == CLK_DIV-1. CLK_DIV=1 gives pix_en constantly high after the first post-reset cycle.
- On each Clk edge with pix_en high:
  - hCount increments; at H_TOTAL-1 it wraps to 0.
  - vCount increments when hCount wraps; at V_TOTAL-1 it wraps to 0.
- Active window, all values inclusive:
  - horizontal: H_SYNC+H_BP .. H_SYNC+H_BP+H_DISP-1, i.e. 144..783
  - vertical: V_SYNC+V_BP .. V_SYNC+V_BP+V_DISP-1, i.e. 35..514
  - Bright = horizontal window AND vertical window.
- hSync, vSync, Bright, pixel_x and pixel_y are registered. They are decoded from the next counter values, so in every cycle they are consistent with the hCount/vCount being output. There is no skew between coordinates and flags.
- frame_tick is set on the edge that loads (hCount,vCount) = (0,515). It is high for that one following Clk cycle only, never for the full CLK_DIV hold.
- Frame counter fcnt counts frame_ticks 0..TICK_FRAMES-1. move_tick is asserted in the same cycle as the frame_tick that wraps fcnt to 0. With TICK_FRAMES=1, move_tick equals frame_tick.
- Reset values: div_cnt=0, pix_en=0, hCount=0, vCount=0, hSync=0, vSync=0, Bright=0, pixel_x=0, pixel_y=0, frame_tick=0, move_tick=0, fcnt=0.
- Reset mid-frame: everything returns to the reset values on that edge. No partial line is completed and no tick is emitted on the reset edge.

## Timing
- First pix_en occurs in Clk cycle CLK_DIV after Reset deasserts (cycle 4 for the default). hCount becomes 1 on that edge.
- Line length is H_TOTAL*CLK_DIV = 3200 Clk. Frame length is 525 lines = 1,680,000 Clk.
- hSync low for 96 pixels per line. vSync low for lines 0..1 of every frame.
- frame_tick period is exactly one frame. move_tick period is TICK_FRAMES frames; the first move_tick follows the TICK_FRAMES-th frame_tick after reset.
- Latency: zero cycles between any counter value and its derived flags and coordinates.
- Counter widths: hCount is 10 bits (max 799) and vCount is 10 bits (max 524). No arithmetic overflow is possible with the default parameters. pixel_y is truncated to 9 bits; its maximum is 479.

## Structure
- Shared package vga_timing_pkg holds:
  - the segment length defaults
  - derived H_TOTAL, V_TOTAL, H_ACT_START=144, H_ACT_END=783, V_ACT_START=35, V_ACT_END=514
  - localparam widths
- Renderers import the same package rather than hard-coding 144/35.
- One sub-module, pix_en_div, contains the div_cnt divider and the pix_en register, parameterised on CLK_DIV. Counters, decode and the tick logic stay in vga_sync_gen.

## Test plan
- Reset released at cycle 0, CLK_DIV=4 -> pix_en high in cycles 3, 7, 11 after release; hCount=1 from cycle 4; all other outputs hold their reset values.
- Run one line -> hSync low for hCount 0..95 (384 Clk). hCount wraps 799->0 and vCount increments 0->1 on the same edge.
- Scan line 35 -> Bright rises with hCount=144, pixel_x=0, pixel_y=0. Bright falls at hCount=784. Line 515 has Bright=0 throughout.
- Full frame -> vSync low only on lines 0..1. frame_tick is a single 1-Clk pulse with hCount=0, vCount=515. vCount wraps 524->0.
- TICK_FRAMES=3 over 7 frames -> move_tick coincides with frame_ticks 3 and 6 only. TICK_FRAMES=1 -> move_tick equals frame_tick.
- Reset asserted at hCount=500, vCount=300 -> next cycle shows all reset values. Reset asserted on the frame_tick edge -> no frame_tick and no move_tick pulse.
